// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers for the parametrised FIFO.
//   clog2          - ceiling log2 of an unsigned value (0 and 1 both map to 0)
//   fifo_ptr_w     - pointer width for a given depth (index bits + wrap bit)
//   fifo_cnt_w     - occupancy counter width for a given depth (0..DEPTH)
//   fifo_is_pow2   - power-of-two test used by the parameter check
//   fifo_params_legal - full parameter legality check for fifo_param
package fifo_pkg;

  // Ceiling log2 as a constant function, usable in port declarations.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 32'd1;
    end
    return result;
  endfunction

  // One extra bit above the storage index tells full from empty.
  function automatic int unsigned fifo_ptr_w(input int unsigned depth);
    return clog2(depth) + 32'd1;
  endfunction

  // Count is the pointer difference, so it shares the pointer width.
  function automatic int unsigned fifo_cnt_w(input int unsigned depth);
    return fifo_ptr_w(depth);
  endfunction

  function automatic bit fifo_is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 32'd1)) == 0);
  endfunction

  // Natural pointer wrap only works for power-of-two depths.
  function automatic bit fifo_params_legal(input int unsigned data_width,
                                           input int unsigned depth,
                                           input int unsigned af_level,
                                           input int unsigned ae_level);
    return (data_width >= 1) &&
           (depth >= 2) && fifo_is_pow2(depth) &&
           (af_level >= 1) && (af_level <= depth) &&
           (ae_level <= depth - 32'd1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x DATA_WIDTH storage, one synchronous write port and one
// asynchronous read port. Contents are not reset.
//   clk   - write clock
//   we    - write enable
//   waddr - write index
//   wdata - write data
//   raddr - read index
//   rdata - read data (combinational from raddr)
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]     rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Show-ahead read port.
  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with show-ahead read port,
// occupancy count, almost-full/almost-empty flags and acceptance of a push
// while full when a pop happens in the same cycle.
// Optional sticky overflow/underflow flags when FIFO_PARAM_ERRFLAGS_EN is
// defined; otherwise they are tied low and io_err_clr is ignored.
//   clk             - clock, rising edge
//   reset           - asynchronous active-low reset
//   io_din/io_push  - push data / push request
//   io_pop          - pop request
//   io_dout         - head entry (undefined while empty)
//   io_empty/io_full, io_count - occupancy status
//   io_almost_full  - count >= AF_LEVEL
//   io_almost_empty - count <= AE_LEVEL
//   io_err_clr      - clears sticky error flags
//   io_overflow     - sticky: push rejected
//   io_underflow    - sticky: pop rejected
module fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_LEVEL   = 12,
  parameter int unsigned AE_LEVEL   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         io_din,
  input  logic                          io_push,
  input  logic                          io_pop,
  output logic [DATA_WIDTH-1:0]         io_dout,
  output logic                          io_empty,
  output logic                          io_full,
  output logic [fifo_cnt_w(DEPTH)-1:0]  io_count,
  output logic                          io_almost_full,
  output logic                          io_almost_empty,
  input  logic                          io_err_clr,
  output logic                          io_overflow,
  output logic                          io_underflow
);

  localparam int unsigned IDX_W      = clog2(DEPTH);
  localparam int unsigned FIFO_PTR_W = fifo_ptr_w(DEPTH);
  localparam int unsigned FIFO_CNT_W = fifo_cnt_w(DEPTH);

  // Elaboration-time parameter check.
  if (!fifo_params_legal(DATA_WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_check
    $error("fifo_param: illegal DATA_WIDTH/DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [FIFO_PTR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic [FIFO_PTR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic                  empty, full;
  logic                  push_ok, pop_ok;
  logic [FIFO_CNT_W-1:0] count;

  // Equal pointers mean empty; same index with opposite wrap bits means full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                 (wr_ptr[FIFO_PTR_W-1] != rd_ptr[FIFO_PTR_W-1]);

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push.
  assign pop_ok  = io_pop & ~empty;
  assign push_ok = io_push & (~full | io_pop);

  // Modular difference gives 0..DEPTH directly.
  assign count = FIFO_CNT_W'(wr_ptr - rd_ptr);

  // Next-pointer logic.
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    if (pop_ok)  rd_ptr_nxt = rd_ptr + FIFO_PTR_W'(1);
    if (push_ok) wr_ptr_nxt = wr_ptr + FIFO_PTR_W'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr[IDX_W-1:0]),
    .wdata (io_din),
    .raddr (rd_ptr[IDX_W-1:0]),
    .rdata (io_dout)
  );

  assign io_empty        = empty;
  assign io_full         = full;
  assign io_count        = count;
  assign io_almost_full  = (count >= FIFO_CNT_W'(AF_LEVEL));
  assign io_almost_empty = (count <= FIFO_CNT_W'(AE_LEVEL));

`ifdef FIFO_PARAM_ERRFLAGS_EN
  logic overflow_q, underflow_q;

  // Sticky error flags; clear wins over a same-cycle set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (io_err_clr) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (io_push & ~push_ok) overflow_q  <= 1'b1;
      if (io_pop & empty)     underflow_q <= 1'b1;
    end
  end

  assign io_overflow  = overflow_q;
  assign io_underflow = underflow_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = io_err_clr;
  assign io_overflow    = 1'b0;
  assign io_underflow   = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed bench for fifo_param with a queue-based reference
// model checked every cycle, plus hand-computed literal expectations.
module tb_fifo_param;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 12;
  localparam int unsigned AE    = 4;

`ifdef FIFO_PARAM_ERRFLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] din;
  logic          push, pop, err_clr;
  logic [DW-1:0] dout;
  logic          empty, full, af, ae, ovf, unf;
  logic [4:0]    count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_param #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .io_din          (din),
    .io_push         (push),
    .io_pop          (pop),
    .io_dout         (dout),
    .io_empty        (empty),
    .io_full         (full),
    .io_count        (count),
    .io_almost_full  (af),
    .io_almost_empty (ae),
    .io_err_clr      (err_clr),
    .io_overflow     (ovf),
    .io_underflow    (unf)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue plus sticky flags.
  logic [DW-1:0] q[$];
  bit            m_ovf, m_unf;
  int            m_n;
  bit            m_pop_acc, m_push_acc;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_n        = q.size();
      m_pop_acc  = pop && (m_n > 0);
      m_push_acc = push && ((m_n < int'(DEPTH)) || pop);
      if (ERR_EN) begin
        if (err_clr) begin
          m_ovf = 1'b0;
          m_unf = 1'b0;
        end else begin
          if (push && !m_push_acc) m_ovf = 1'b1;
          if (pop && m_n == 0)     m_unf = 1'b1;
        end
      end
      if (m_pop_acc)  void'(q.pop_front());
      if (m_push_acc) q.push_back(din);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("cyc_count", int'(count), q.size());
      chk("cyc_empty", int'(empty), int'(q.size() == 0));
      chk("cyc_full",  int'(full),  int'(q.size() == int'(DEPTH)));
      chk("cyc_af",    int'(af),    int'(q.size() >= int'(AF)));
      chk("cyc_ae",    int'(ae),    int'(q.size() <= int'(AE)));
      if (q.size() > 0) chk("cyc_dout", int'(dout), int'(q[0]));
      chk("cyc_ovf",   int'(ovf),   int'(m_ovf));
      chk("cyc_unf",   int'(unf),   int'(m_unf));
    end
  end

  task automatic step(input bit pu, input bit po, input logic [DW-1:0] d, input bit clr);
    push    = pu;
    pop     = po;
    din     = d;
    err_clr = clr;
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic fill_seq();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, DW'(i), 1'b0);
  endtask

  initial begin
    reset   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    din     = '0;
    err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", int'(empty), 1);
    chk("rst_count", int'(count), 0);
    chk("rst_ae",    int'(ae),    1);
    chk("rst_full",  int'(full),  0);
    chk("rst_af",    int'(af),    0);
    chk("rst_ovf",   int'(ovf),   0);
    chk("rst_unf",   int'(unf),   0);
    reset = 1'b1;
    step(1'b0, 1'b0, '0, 1'b0);

    // Fill: almost-full first after the 12th push.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, DW'(i), 1'b0);
      chk("fill_af", int'(af), int'(i + 1 >= 12));
    end
    chk("fill_count", int'(count), 16);
    chk("fill_full",  int'(full),  1);

    // Drain in order; almost-empty once count <= 4.
    for (int i = 0; i < 16; i++) begin
      chk("drain_dout", int'(dout), i);
      step(1'b0, 1'b1, '0, 1'b0);
      chk("drain_ae", int'(ae), int'(15 - i <= 4));
    end
    chk("drain_empty", int'(empty), 1);

    // Pointer wrap over three rounds of ten.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, DW'(8'hA0 + i), 1'b0);
      chk("wrap_count10", int'(count), 10);
      for (int i = 0; i < 10; i++) begin
        chk("wrap_dout", int'(dout), 8'hA0 + i);
        step(1'b0, 1'b1, '0, 1'b0);
      end
      chk("wrap_count0", int'(count), 0);
    end

    // Full with simultaneous push and pop.
    fill_seq();
    step(1'b1, 1'b1, 8'h55, 1'b0);
    chk("fullpp_count", int'(count), 16);
    chk("fullpp_full",  int'(full),  1);
    chk("fullpp_ovf",   int'(ovf),   0);
    for (int i = 0; i < 16; i++) begin
      chk("fullpp_dout", int'(dout), (i < 15) ? i + 1 : 8'h55);
      step(1'b0, 1'b1, '0, 1'b0);
    end
    chk("fullpp_empty", int'(empty), 1);

    // Empty with simultaneous push and pop: only the push lands.
    step(1'b1, 1'b1, 8'h77, 1'b0);
    chk("emptypp_count", int'(count), 1);
    chk("emptypp_dout",  int'(dout),  8'h77);
    chk("emptypp_unf",   int'(unf),   int'(ERR_EN));
    step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("clr1_unf", int'(unf), 0);

    // Overflow: push while full without pop.
    fill_seq();
    step(1'b1, 1'b0, 8'hEE, 1'b0);
    chk("ovf_flag",  int'(ovf),   int'(ERR_EN));
    chk("ovf_count", int'(count), 16);
    chk("ovf_head",  int'(dout),  0);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_drain", int'(dout), i);
      step(1'b0, 1'b1, '0, 1'b0);
    end
    // Underflow: pop while empty.
    step(1'b0, 1'b1, '0, 1'b0);
    chk("unf_flag",  int'(unf),   int'(ERR_EN));
    chk("unf_ovf",   int'(ovf),   int'(ERR_EN));
    chk("unf_count", int'(count), 0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("clr_ovf", int'(ovf), 0);
    chk("clr_unf", int'(unf), 0);
    // Clear beats a same-cycle set.
    step(1'b0, 1'b1, '0, 1'b1);
    chk("clrprio_unf", int'(unf), 0);

    // Asynchronous reset mid-operation discards contents.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(8'h30 + i), 1'b0);
    chk("pre_rst_count", int'(count), 3);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_empty", int'(empty), 1);
    chk("async_rst_count", int'(count), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b1, 1'b0, 8'h42, 1'b0);
    chk("post_rst_dout",  int'(dout),  8'h42);
    chk("post_rst_count", int'(count), 1);
    step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous single-clock FIFO. Successor to the 2-bit, 2-entry FIFO.
- Generalises data width and depth.
- Adds occupancy count, programmable almost-full/almost-empty flags, and push-while-full-with-pop acceptance.
- Sits between producer/consumer stages in generated datapaths. Show-ahead (first-word-fall-through) read port, as before.

Parameters:
- DATA_WIDTH, 8: bits per entry, ≥1.
- DEPTH, 16: number of entries; power of two, ≥2.
- AF_LEVEL, 12: io_almost_full asserts when count ≥ AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 4: io_almost_empty asserts when count ≤ AE_LEVEL; range 0..DEPTH-1.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset (asserted at 0).
- io_din, input, DATA_WIDTH: push data.
- io_push, input, 1: push request.
- io_pop, input, 1: pop request.
- io_dout, output, DATA_WIDTH: head entry (show-ahead).
- io_empty, output, 1: count == 0.
- io_full, output, 1: count == DEPTH.
- io_count, output, log2(DEPTH)+1: current occupancy, 0..DEPTH.
- io_almost_full, output, 1: count ≥ AF_LEVEL.
- io_almost_empty, output, 1: count ≤ AE_LEVEL.
- io_err_clr, input, 1: clears sticky error flags (optional feature).
- io_overflow, output, 1: sticky; push rejected (optional feature).
- io_underflow, output, 1: sticky; pop rejected (optional feature).

Behaviour:
- Pointers
  - rd_ptr and wr_ptr are each log2(DEPTH)+1 bits.
  - The low bits index storage; the MSB is the wrap bit.
  - Both increment modulo 2·DEPTH (natural wrap).
- Flags and count
  - empty = (wr_ptr == rd_ptr).
  - full = (index bits equal) AND (wrap bits differ).
  - io_count = wr_ptr − rd_ptr, computed modulo 2^(log2(DEPTH)+1). It is combinational from the pointers.
- Accepted operations
  - pop_ok = io_pop & ~empty.
  - push_ok = io_push & (~full | io_pop).
  - If full and push and pop coincide, both are accepted. Count stays DEPTH.
  - If empty and push and pop coincide, only the push is accepted. Pop is rejected; the new data appears on io_dout the next cycle.
- Write
  - On push_ok, mem[wr_ptr index] ← io_din at the rising edge, and wr_ptr increments.
  - Storage has no reset.
- Read
  - io_dout = mem[rd_ptr index] combinationally (zero-latency show-ahead).
  - On pop_ok, rd_ptr increments.
  - io_dout is undefined when empty. The bench must not check it then.
- Latency
  - A push at edge N makes data visible on io_dout after edge N when the FIFO was empty (one-cycle fall-through).
  - Flags and count reflect an operation after the same edge.
- Reset (reset=0, asynchronous)
  - rd_ptr = wr_ptr = 0.
  - Outputs: io_empty=1, io_full=0, io_count=0, io_almost_empty=1, io_almost_full=0, io_overflow=0, io_underflow=0.
  - Reset mid-operation discards all contents. Deassertion is assumed synchronised externally.
- State: no FSM beyond the pointer pair (and error flags when enabled).

Optional Feature:
- Macro: FIFO_PARAM_ERRFLAGS_EN.
- Defined:
  - io_overflow sets on io_push & ~push_ok (push while full without pop).
  - io_underflow sets on io_pop & empty.
  - Both flags hold until io_err_clr=1 at an edge. Clear has priority over a same-cycle set.
- Undefined:
  - io_overflow and io_underflow are tied 0.
  - io_err_clr is ignored.
  - No flag registers are generated.

Decomposition:
- Package fifo_pkg:
  - ptr-width function clog2.
  - FIFO_PTR_W/FIFO_CNT_W derived constants.
  - Parameter-legality checks (DEPTH power of two; level ranges).
- Sub-module fifo_ram:
  - DEPTH×DATA_WIDTH array.
  - One synchronous write port, one asynchronous read port.
  - Top block holds pointers, flags and the optional error logic.

Test Plan:
- Reset then idle: reset=0 for 2 cycles → io_empty=1, io_count=0, io_almost_empty=1, io_full=0.
- Fill: DATA_WIDTH=8, DEPTH=16; push 0x00..0x0F over 16 cycles → io_count=16, io_full=1, io_almost_full first asserted after the 12th push.
- Drain and order: pop 16 times → io_dout sequence 0x00..0x0F, io_empty=1 after the last pop, io_almost_empty asserted once count≤4.
- Wrap: push 10, pop 10, repeat 3 times with data 0xA0+i → pointers wrap; FIFO order preserved; io_count returns to 0 each time.
- Simultaneous events:
  - Full with push 0x55 and pop in the same cycle → io_count stays 16; 0x55 emerges last.
  - Empty with push 0x77 and pop → io_count=1, io_dout=0x77 next cycle.
- Errors (macro on):
  - Push when full without pop → io_overflow=1, count unchanged.
  - Pop when empty → io_underflow=1.
  - io_err_clr=1 → both 0.
  - Macro off: both flags stay 0 under the same stimulus.
